// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 16-bit unsigned shift-and-add multiplier.
// One partial-product step per clock through a carry-lookahead adder; the result is a*b mod 2^16.

// 16-bit carry-lookahead adder: 4-bit groups with lookahead carries inside each group and across groups.
module s16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Bit carries are formed from the group carry-in only, never from each other.
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign s    = p ^ c;
  assign cout = gc[4];
endmodule

// Handshake: start is accepted on an edge where busy=0 (IDLE or DONE); busy stays high for
// exactly 16 cycles, then done pulses for one cycle while o holds the product until the next start.
module mul16_seq (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] sum;
  logic        unused_cout;
  logic        start_ok;

  s16bit u_add (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .s    (sum),
    .cout (unused_cout)
  );

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        if (mplier[0]) acc <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 4'd1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign o    = acc;
endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: directed corner cases plus random operands, checked against a*b mod 2^16
// and the fixed 16-cycle busy window.
module tb_mul16_seq;
  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] o;

  int n_total;
  int n_bad;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  mul16_seq dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .o     (o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] full;
    full = 32'(x) * 32'(y);
    return full[15:0];
  endfunction

  // Accept a start (from IDLE or DONE); afterwards the DUT is in the first RUN cycle.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    tick();
    start = 1'b0;
    check("launch_busy", 16'(busy), 16'd1);
    check("launch_o_clear", o, 16'h0000);
  endtask

  // Walk the 16 RUN cycles, optionally hammering start/a/b, and check the done cycle.
  task automatic run_and_check(input bit noise, input bit all_ones);
    for (int i = 0; i < 16; i++) begin
      check("run_busy", 16'(busy), 16'd1);
      check("run_done", 16'(done), 16'd0);
      if (noise) begin
        start = 1'b1;
        a = all_ones ? 16'hFFFF : 16'($urandom);
        b = all_ones ? 16'hFFFF : 16'($urandom);
      end
      tick();
    end
    start = 1'b0;
    check("done_pulse", 16'(done), 16'd1);
    check("done_busy", 16'(busy), 16'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      last_exp = exp_q.pop_front();
      check("product", o, last_exp);
    end
  endtask

  task automatic finish_idle(input int gap);
    start = 1'b0;
    for (int i = 0; i <= gap; i++) begin
      tick();
      check("idle_done", 16'(done), 16'd0);
      check("idle_busy", 16'(busy), 16'd0);
      check("idle_hold", o, last_exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    last_exp = '0;
    nrst = 1'b0;
    start = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    tick();
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_o", o, 16'h0000);
    start = 1'b0;
    nrst = 1'b1;
    tick();
    check("post_rst_idle", 16'(busy), 16'd0);

    // directed corner products
    launch(16'd3, 16'd5);           run_and_check(0, 0); finish_idle(1);
    launch(16'hFFFF, 16'hFFFF);     run_and_check(0, 0); finish_idle(0);
    launch(16'h0100, 16'h0100);     run_and_check(0, 0); finish_idle(0);
    launch(16'h00FF, 16'h0101);     run_and_check(0, 0); finish_idle(0);
    launch(16'h1234, 16'h0000);     run_and_check(0, 0); finish_idle(0);
    launch(16'h0000, 16'hBEEF);     run_and_check(0, 0); finish_idle(0);

    // start and operand changes while busy are ignored
    launch(16'd7, 16'd9);           run_and_check(1, 1); finish_idle(2);

    // reset in the middle of RUN aborts without a done pulse
    launch(16'd100, 16'd200);
    for (int i = 0; i < 8; i++) tick();
    check("mid_busy", 16'(busy), 16'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    void'(exp_q.pop_back());
    last_exp = 16'h0000;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_o", o, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_done", 16'(done), 16'd0);
    end
    launch(16'd2, 16'd3);           run_and_check(0, 0); finish_idle(0);

    // back-to-back start in the DONE cycle
    launch(16'd7, 16'd9);           run_and_check(0, 0);
    launch(16'd11, 16'd13);
    check("b2b_done_single", 16'(done), 16'd0);
    run_and_check(0, 0);
    finish_idle(1);

    // random operands, random noise, random back-to-back vs idle gaps
    for (int k = 0; k < 40; k++) begin
      launch(16'($urandom), 16'($urandom));
      run_and_check(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) finish_idle($urandom_range(0, 3));
    end
    finish_idle(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16 bits.
REQ-002 Port `clk`: input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 Port `nrst`: input, 1 bit; reset, synchronous and active-low.
REQ-004 Port `start`: input, 1 bit; request to begin a multiplication, sampled on the rising edge.
REQ-005 Port `a`: input, 16 bits; unsigned multiplicand, bit index 0 = LSB, captured only when start is accepted.
REQ-006 Port `b`: input, 16 bits; unsigned multiplier, bit index 0 = LSB, captured only when start is accepted.
REQ-007 Port `busy`: output, 1 bit; high while a multiplication is in progress.
REQ-008 Port `done`: output, 1 bit; single-cycle pulse marking the cycle in which the result is final.
REQ-009 Port `o`: output, 16 bits; product a*b mod 2^16, bit index 0 = LSB.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 Registers SHALL be: mcand (16 bits), mplier (16 bits), acc (16 bits), and a 4-bit step counter cnt.
REQ-012 Start acceptance: start=1 on an edge in IDLE or DONE SHALL load mcand=a, mplier=b, acc=0, cnt=0, and move to RUN.
REQ-013 In IDLE with start=0, the FSM SHALL stay in IDLE. In DONE with start=0, it SHALL move to IDLE.
REQ-014 Each RUN edge SHALL do all of the following:
- if mplier[0]=1, acc <= acc + mcand; otherwise acc holds;
- mcand <= mcand << 1 (zero fill);
- mplier <= mplier >> 1 (zero fill);
- cnt <= cnt + 1.
REQ-015 The RUN addition SHALL use one instance of the team's 16-bit carry-lookahead adder (s16bit) with carry-in 0; the carry out of bit 15 SHALL be discarded.
REQ-016 The FSM SHALL leave RUN for DONE on the RUN edge where cnt=15, so RUN lasts exactly 16 edges, with no early termination for zero operands.
REQ-017 busy SHALL be 1 exactly when the state is RUN.
REQ-018 done SHALL be 1 exactly when the state is DONE.
REQ-019 Latency: when start is accepted at edge E0, done SHALL be high in the cycle following edge E16, and o SHALL equal the product from edge E16 onward.
REQ-020 o SHALL be driven from acc in every state. After DONE, o SHALL hold the last product until the next accepted start clears acc.
REQ-021 start while busy=1 SHALL be ignored, and changes to a/b while busy=1 SHALL NOT affect the result.
REQ-022 start accepted in the DONE cycle SHALL begin the next operation back-to-back. done SHALL still be a single-cycle pulse, and o SHALL read 0 from the following cycle.
REQ-023 The product SHALL be exact modulo 2^16 for all 2^32 operand pairs.

Reset
REQ-024 nrst=0 at a rising edge SHALL force: state=IDLE, mcand=0, mplier=0, acc=0, cnt=0.
REQ-025 Consequently, during reset busy=0, done=0 and o=0 from the next cycle.
REQ-026 Reset SHALL take priority over start and over any in-progress RUN step.
REQ-027 An operation aborted by reset SHALL produce no done pulse.
REQ-028 After reset is released, the first start with nrst=1 SHALL be accepted normally.

Verification
REQ-029 a=3, b=5, start for 1 cycle -> busy high for 16 cycles, done pulses once, o=15 (0x000F).
REQ-030 a=0xFFFF, b=0xFFFF -> o=0x0001. a=0x0100, b=0x0100 -> o=0x0000. a=0x00FF, b=0x0101 -> o=0xFFFF.
REQ-031 a=0x1234, b=0 and a=0, b=0xBEEF -> o=0 after the full 16-cycle latency, and done still pulses.
REQ-032 Start a=7, b=9; mid-RUN, drive a=b=0xFFFF with start=1 for several cycles -> start ignored, o=63, exactly one done pulse.
REQ-033 Start a=100, b=200; assert nrst=0 at RUN step 8 -> busy=0, done=0, o=0 next cycle, no done later. Then start a=2, b=3 -> o=6.
REQ-034 Start a=7, b=9, then start a=11, b=13 held high in the DONE cycle -> o=63 with done, o=0 next cycle, then after 16 more RUN cycles o=143 with a second single done pulse.
